// File: rtl/uart_tx.sv
// UART transmitter: start bit, DBIT data bits LSB first, then 1 or 2 stop bits.
// Bit timing is taken from an external 16x oversampling tick.
module uart_tx #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       s_tick,
    input  logic       snum,
    input  logic       tx_start,
    input  logic [7:0] d_tx,
    output logic       tx,
    output logic       tx_done,
    output logic       txing
);

    // state | meaning
    // IDLE  | line high, waiting for tx_start
    // START | start bit (low), 16 ticks
    // DATA  | shifting data bits out LSB first, 16 ticks each
    // STOP  | line high for 1 or 2 stop bits of SB_TICK ticks each
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    localparam int              STW    = (SB_TICK > 1) ? $clog2(2 * SB_TICK) : 1;
    localparam logic [STW-1:0]  STOP1  = STW'(SB_TICK - 1);
    localparam logic [STW-1:0]  STOP2  = STW'(2 * SB_TICK - 1);
    localparam logic [2:0]      N_LAST = 3'(DBIT - 1);

    state_t         state;
    logic [3:0]     s_cnt;
    logic [2:0]     n;
    logic [7:0]     shift;
    logic [STW-1:0] stop_cnt;
    logic           snum_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            s_cnt    <= '0;
            n        <= '0;
            shift    <= '0;
            stop_cnt <= '0;
            snum_q   <= 1'b0;
            tx       <= 1'b1;
            tx_done  <= 1'b0;
            txing    <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            case (state)
                IDLE: begin
                    tx    <= 1'b1;
                    txing <= 1'b0;
                    if (tx_start) begin
                        shift  <= d_tx;
                        s_cnt  <= '0;
                        snum_q <= snum;
                        tx     <= 1'b0;
                        txing  <= 1'b1;
                        state  <= START;
                    end
                end
                START: begin
                    if (s_tick) begin
                        if (s_cnt == 4'd15) begin
                            s_cnt <= '0;
                            n     <= '0;
                            tx    <= shift[0];
                            state <= DATA;
                        end else begin
                            s_cnt <= s_cnt + 4'd1;
                        end
                    end
                end
                DATA: begin
                    if (s_tick) begin
                        if (s_cnt == 4'd15) begin
                            s_cnt <= '0;
                            shift <= shift >> 1;
                            // tx is registered, so it is loaded with the bit that shifts into place
                            if (n == N_LAST) begin
                                tx       <= 1'b1;
                                stop_cnt <= snum_q ? STOP2 : STOP1;
                                state    <= STOP;
                            end else begin
                                tx <= shift[1];
                                n  <= n + 3'd1;
                            end
                        end else begin
                            s_cnt <= s_cnt + 4'd1;
                        end
                    end
                end
                STOP: begin
                    if (s_tick) begin
                        if (stop_cnt == '0) begin
                            tx_done <= 1'b1;
                            txing   <= 1'b0;
                            state   <= IDLE;
                        end else begin
                            stop_cnt <= stop_cnt - 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: stimulus queues expected frames, a monitor decodes tx
// at mid-bit tick positions and checks each frame when tx_done pulses.
module tb_uart_tx;

    logic       clk;
    logic       reset_n;
    logic       s_tick;
    logic       snum;
    logic       tx_start;
    logic [7:0] d_tx;
    logic       tx;
    logic       tx_done;
    logic       txing;

    int n_tests = 0;
    int n_fail  = 0;

    logic tick_en  = 1'b1;
    int   tick_per = 4;

    typedef struct {
        logic [10:0] bits;
        int          total;
    } exp_t;

    exp_t exp_q[$];

    uart_tx #(.DBIT(8), .SB_TICK(16)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .s_tick   (s_tick),
        .snum     (snum),
        .tx_start (tx_start),
        .d_tx     (d_tx),
        .tx       (tx),
        .tx_done  (tx_done),
        .txing    (txing)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic fail_now(input string name, input int act);
        n_tests++;
        n_fail++;
        $display("FAIL %s: observed value %0d", name, act);
    endtask

    // bit 0 start, bits 8:1 data LSB first, bit 9 stop, bit 10 second stop
    function automatic exp_t mk(input logic [7:0] d, input logic sn);
        exp_t e;
        e.bits  = {sn, 1'b1, d, 1'b0};
        e.total = 16 * 9 + 16 * (sn ? 2 : 1);
        return e;
    endfunction

    // baud tick driver, changes 1 ns after posedge
    initial begin
        int tcnt;
        tcnt   = 0;
        s_tick = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (tick_en) begin
                tcnt++;
                s_tick = (tcnt % tick_per == 0);
            end else begin
                s_tick = 1'b0;
            end
        end
    end

    // monitor: at each negedge, ticks = ticks already consumed by the DUT
    initial begin
        logic        prev_tx;
        logic        active;
        logic        busy_bad;
        logic [10:0] got;
        int          ticks;
        int          idx;
        int          cyc;
        exp_t        e;
        prev_tx  = 1'b1;
        active   = 1'b0;
        busy_bad = 1'b0;
        got      = '0;
        ticks    = 0;
        idx      = 0;
        cyc      = 0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                active  = 1'b0;
                prev_tx = 1'b1;
            end else begin
                if (!active && prev_tx && !tx) begin
                    if (exp_q.size() == 0) begin
                        fail_now("unexpected_frame", exp_q.size());
                    end else begin
                        active   = 1'b1;
                        ticks    = 0;
                        idx      = 0;
                        cyc      = 0;
                        got      = '0;
                        busy_bad = 1'b0;
                    end
                end
                if (tx_done) begin
                    if (!active) begin
                        fail_now("spurious_done", exp_q.size());
                    end else begin
                        e = exp_q.pop_front();
                        check("frame_bits", int'(got), int'(e.bits));
                        check("frame_ticks", ticks, e.total);
                        check("txing_busy", int'(busy_bad), 0);
                        active = 1'b0;
                    end
                end else if (active) begin
                    cyc++;
                    if (!txing) busy_bad = 1'b1;
                    if (idx < 11 && ticks == 8 + 16 * idx) begin
                        got[idx] = tx;
                        idx++;
                    end
                    if (cyc > 3000) begin
                        fail_now("frame_timeout", cyc);
                        active = 1'b0;
                    end
                    if (s_tick) ticks++;
                end
                prev_tx = tx;
            end
        end
    end

    task automatic send(input logic [7:0] d, input logic sn);
        @(posedge clk);
        #1;
        d_tx     = d;
        snum     = sn;
        tx_start = 1'b1;
        exp_q.push_back(mk(d, sn));
        @(posedge clk);
        #1;
        tx_start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int limit);
        logic found;
        found = 1'b0;
        for (int k = 0; k < limit && !found; k++) begin
            @(negedge clk);
            if (tx_done) found = 1'b1;
        end
        if (!found) fail_now(name, limit);
    endtask

    initial begin
        reset_n  = 1'b0;
        snum     = 1'b0;
        tx_start = 1'b0;
        d_tx     = 8'h00;
        #12;
        check("reset_tx", int'(tx), 1);
        check("reset_txing", int'(txing), 0);
        check("reset_done", int'(tx_done), 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (5) @(posedge clk);

        // 0xA5, one stop bit: 0,1,0,1,0,0,1,0,1,1 over 160 ticks
        send(8'hA5, 1'b0);
        wait_done("timeout_a5", 1500);

        // 0x00, two stop bits, snum wiggled mid-frame
        send(8'h00, 1'b1);
        repeat (200) @(posedge clk);
        #1 snum = 1'b0;
        repeat (100) @(posedge clk);
        #1 snum = 1'b1;
        wait_done("timeout_00", 1500);
        snum = 1'b0;

        // tx_start held high: 0x55 then 0x3C back to back
        @(posedge clk);
        #1;
        d_tx     = 8'h55;
        snum     = 1'b0;
        tx_start = 1'b1;
        exp_q.push_back(mk(8'h55, 1'b0));
        @(posedge clk);
        #1;
        d_tx = 8'h3C;
        exp_q.push_back(mk(8'h3C, 1'b0));
        wait_done("timeout_55", 1500);
        @(negedge clk);
        check("b2b_start_tx", int'(tx), 0);
        check("b2b_start_txing", int'(txing), 1);
        tx_start = 1'b0;
        wait_done("timeout_3c", 1500);

        // tx_start during DATA must be ignored
        send(8'h96, 1'b0);
        repeat (300) @(posedge clk);
        #1;
        d_tx     = 8'hFF;
        tx_start = 1'b1;
        @(posedge clk);
        #1;
        tx_start = 1'b0;
        wait_done("timeout_96", 1500);
        repeat (50) @(negedge clk);
        check("no_queued_frame", int'(txing), 0);

        // tick stall mid-START
        send(8'hC3, 1'b0);
        repeat (20) @(posedge clk);
        #1 tick_en = 1'b0;
        repeat (100) @(posedge clk);
        @(negedge clk);
        check("stall_tx", int'(tx), 0);
        check("stall_txing", int'(txing), 1);
        tick_en = 1'b1;
        wait_done("timeout_c3", 1800);

        // reset mid-DATA
        send(8'hA5, 1'b0);
        repeat (150) @(posedge clk);
        #1 reset_n = 1'b0;
        #1;
        check("midreset_tx", int'(tx), 1);
        check("midreset_txing", int'(txing), 0);
        check("midreset_done", int'(tx_done), 0);
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        check("post_reset_tx", int'(tx), 1);
        check("post_reset_txing", int'(txing), 0);
        send(8'h5A, 1'b0);
        wait_done("timeout_5a", 1500);

        repeat (10) @(posedge clk);
        check("queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
